// File: rtl/tile_scheduler.sv
// tile_scheduler: walks a rectangular grid of tiles in row-major order and
// issues one tile_processor job per tile. It waits for each tile to finish and
// reports the job outcome as ok, watchdog timeout or host abort.
//
// Tile handshake: tp_start is a one-cycle request. tp_tile_i/j and tp_op_code
// stay stable from that cycle until the tile completes. A tile counts as
// complete only on a rising edge of tp_done, so a done level left high by the
// previous tile can never complete the next one.
module tile_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] cfg_op_code,
    input  logic [2:0] cfg_rows,
    input  logic [2:0] cfg_cols,
    output logic       tp_start,
    output logic [2:0] tp_tile_i,
    output logic [2:0] tp_tile_j,
    output logic [2:0] tp_op_code,
    input  logic       tp_done,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic [6:0] tiles_done,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [1:0]      ST_OK      = 2'b00;
    localparam logic [1:0]      ST_TIMEOUT = 2'b01;
    localparam logic [1:0]      ST_ABORT   = 2'b10;
    localparam logic [TO_W-1:0] WD_ONE     = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LIM     = TO_W'(TIMEOUT_CYCLES);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [2:0]      r_rows;
    logic [2:0]      r_cols;
    logic [2:0]      r_i;
    logic [2:0]      r_j;
    logic [2:0]      r_op;
    logic [1:0]      r_status;
    logic [6:0]      r_tiles;
    logic [TO_W-1:0] r_wd;
    logic            r_tp_done_d;

    logic            w_edge;
    logic            w_wd_hit;
    logic [TO_W-1:0] w_wd_inc;

    // Datapath strobes produced by the next-state logic.
    logic            w_load;
    logic            w_wd_clr;
    logic            w_wd_step;
    logic            w_tile_inc;
    logic            w_col_step;
    logic            w_row_step;
    logic            w_set_status;
    logic [1:0]      w_status_val;

    assign w_edge   = tp_done & ~r_tp_done_d;
    assign w_wd_inc = r_wd + WD_ONE;
    // A zero limit disables the watchdog entirely.
    assign w_wd_hit = (TIMEOUT_CYCLES != 0) && (w_wd_inc == TO_LIM);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes; abort beats done edge beats timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_wd_clr     = 1'b0;
        w_wd_step    = 1'b0;
        w_tile_inc   = 1'b0;
        w_col_step   = 1'b0;
        w_row_step   = 1'b0;
        w_set_status = 1'b0;
        w_status_val = r_status;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    w_set_status = 1'b1;
                    w_status_val = ST_ABORT;
                    w_state_nxt  = S_FINISH;
                end else begin
                    w_wd_clr    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_set_status = 1'b1;
                    w_status_val = ST_ABORT;
                    w_state_nxt  = S_FINISH;
                end else if (w_edge) begin
                    w_tile_inc  = 1'b1;
                    w_state_nxt = S_NEXT;
                end else begin
                    w_wd_step = 1'b1;
                    if (w_wd_hit) begin
                        w_set_status = 1'b1;
                        w_status_val = ST_TIMEOUT;
                        w_state_nxt  = S_FINISH;
                    end
                end
            end
            S_NEXT: begin
                if (abort) begin
                    w_set_status = 1'b1;
                    w_status_val = ST_ABORT;
                    w_state_nxt  = S_FINISH;
                end else if (r_j < r_cols) begin
                    w_col_step  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (r_i < r_rows) begin
                    w_row_step  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_set_status = 1'b1;
                    w_status_val = ST_OK;
                    w_state_nxt  = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Job configuration, tile position, counters and status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rows   <= 3'd0;
            r_cols   <= 3'd0;
            r_op     <= 3'd0;
            r_i      <= 3'd0;
            r_j      <= 3'd0;
            r_tiles  <= 7'd0;
            r_status <= ST_OK;
            r_wd     <= '0;
        end else begin
            if (w_load) begin
                r_rows   <= cfg_rows;
                r_cols   <= cfg_cols;
                r_op     <= cfg_op_code;
                r_i      <= 3'd0;
                r_j      <= 3'd0;
                r_tiles  <= 7'd0;
                r_status <= ST_OK;
            end
            if (w_col_step) begin
                r_j <= r_j + 3'd1;
            end
            if (w_row_step) begin
                r_j <= 3'd0;
                r_i <= r_i + 3'd1;
            end
            if (w_tile_inc) begin
                r_tiles <= r_tiles + 7'd1;
            end
            if (w_set_status) begin
                r_status <= w_status_val;
            end
            if (w_wd_clr) begin
                r_wd <= '0;
            end else if (w_wd_step) begin
                r_wd <= w_wd_inc;
            end
        end
    end

    // Previous-cycle tp_done, used to find its rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tp_done_d <= 1'b0;
        end else begin
            r_tp_done_d <= tp_done;
        end
    end

    assign tp_start   = (r_state == S_ISSUE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FINISH);
    assign tp_tile_i  = r_i;
    assign tp_tile_j  = r_j;
    assign tp_op_code = r_op;
    assign status     = r_status;
    assign tiles_done = r_tiles;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: table of directed jobs plus randomized jobs checked
// against a tile-level reference model, with hand-written abort and
// mid-job reset sequences.
module tb_tile_scheduler;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] cfg_op_code;
    logic [2:0] cfg_rows;
    logic [2:0] cfg_cols;
    logic       tp_start;
    logic [2:0] tp_tile_i;
    logic [2:0] tp_tile_j;
    logic [2:0] tp_op_code;
    logic       tp_done;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic [6:0] tiles_done;
    logic [2:0] dbg_state;

    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    int         lat_arr[64];
    logic [5:0] exp_q[$];

    typedef struct {
        int rows;
        int cols;
        int op;
        int lat;
        bit held;
        int ab_tile;
        int ab_m;
        int e_pulses;
        int e_status;
        int e_tiles;
    } vec_t;

    vec_t tbl[13];

    // Clock and global time bound.
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    tile_scheduler #(
        .TIMEOUT_CYCLES(TO),
        .TO_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .cfg_op_code(cfg_op_code),
        .cfg_rows(cfg_rows),
        .cfg_cols(cfg_cols),
        .tp_start(tp_start),
        .tp_tile_i(tp_tile_i),
        .tp_tile_j(tp_tile_j),
        .tp_op_code(tp_op_code),
        .tp_done(tp_done),
        .busy(busy),
        .done(done),
        .status(status),
        .tiles_done(tiles_done),
        .dbg_state(dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: walks tiles row-major and decides each tile's fate from
    // its completion latency, the held-done mode and the abort request.
    // e_cycles counts cycles from the first ISSUE to FINISH.
    task automatic model_job(input int rows, input int cols, input bit held,
                             input int ab_tile, input int ab_m,
                             output int e_status, output int e_tiles,
                             output int e_cycles, output logic [5:0] e_last);
        int n;
        bit stop;
        n        = (rows + 1) * (cols + 1);
        e_status = 0;
        e_tiles  = 0;
        e_cycles = 0;
        e_last   = '0;
        stop     = 1'b0;
        exp_q.delete();
        for (int k = 0; k < n && !stop; k++) begin
            int         eff;
            logic [5:0] ij;
            ij = {3'(k / (cols + 1)), 3'(k % (cols + 1))};
            exp_q.push_back(ij);
            e_last = ij;
            eff = (lat_arr[k] == 0 || (held && k > 0)) ? 1000 : lat_arr[k];
            if (k == ab_tile && ab_m <= eff && ab_m <= TO) begin
                e_status = 2;
                e_cycles += 1 + ab_m;
                stop = 1'b1;
            end else if (eff > TO) begin
                e_status = 1;
                e_cycles += 1 + TO;
                stop = 1'b1;
            end else begin
                e_tiles++;
                e_cycles += eff + 2;
            end
        end
    endtask

    // Runs one job with a responding tile model; called with DUT idle,
    // positioned just after a clock edge.
    task automatic run_job(input string tag, input int rows, input int cols, input int op,
                           input bit held, input int ab_tile, input int ab_m,
                           output int pulses, output int st, output int td);
        int         e_status, e_tiles, e_cycles;
        logic [5:0] e_last, ij;
        int         s_cyc, tile_idx, cd, wcnt;
        bit         raised, fin, rise;
        model_job(rows, cols, held, ab_tile, ab_m, e_status, e_tiles, e_cycles, e_last);
        pulses   = 0;
        st       = -1;
        td       = -1;
        tile_idx = -1;
        cd       = 0;
        wcnt     = 0;
        raised   = 1'b0;
        fin      = 1'b0;
        cfg_rows    = 3'(rows);
        cfg_cols    = 3'(cols);
        cfg_op_code = 3'(op);
        start       = 1'b1;
        s_cyc       = cyc;
        for (int n = 0; n < 2000 && !fin; n++) begin
            step();
            start       = 1'($urandom_range(0, 1));
            cfg_rows    = 3'($urandom_range(0, 7));
            cfg_cols    = 3'($urandom_range(0, 7));
            cfg_op_code = 3'($urandom_range(0, 7));
            abort       = 1'b0;
            rise        = 1'b0;
            if (tp_start) begin
                pulses++;
                tile_idx++;
                wcnt = 0;
                cd   = (tile_idx < 64) ? lat_arr[tile_idx] : 0;
                chk({tag, " tp_start expected"}, 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    ij = exp_q.pop_front();
                    chk({tag, " tile ij"}, {tp_tile_i, tp_tile_j}, ij);
                    chk({tag, " tp_op_code"}, tp_op_code, op);
                end
            end else begin
                wcnt++;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) rise = 1'b1;
                end
            end
            if (rise) raised = 1'b1;
            tp_done = rise || (held && raised);
            if (tile_idx == ab_tile && wcnt == ab_m) abort = 1'b1;
            if (done) begin
                fin     = 1'b1;
                start   = 1'b0;
                abort   = 1'b0;
                tp_done = 1'b0;
                st      = status;
                td      = tiles_done;
                chk({tag, " status"}, status, e_status);
                chk({tag, " tiles_done"}, tiles_done, e_tiles);
                chk({tag, " done latency"}, cyc - s_cyc, 1 + e_cycles);
                chk({tag, " leftover tiles"}, exp_q.size(), 0);
                chk({tag, " busy on done"}, busy, 1);
            end
        end
        chk({tag, " done seen"}, fin, 1);
        start = 1'b0;
        abort = 1'b0;
        tp_done = 1'b0;
        step();
        chk({tag, " busy after"}, busy, 0);
        chk({tag, " done one cycle"}, done, 0);
        chk({tag, " tile held in idle"}, {tp_tile_i, tp_tile_j}, e_last);
        chk({tag, " status held"}, status, e_status);
    endtask

    initial begin
        int  pulses, st, td, cd;
        bit  found, seen_done;

        tbl[0]  = '{1, 1, 5, 10, 1'b0, -1, 0,  4, 0,  4};
        tbl[1]  = '{7, 7, 3,  1, 1'b0, -1, 0, 64, 0, 64};
        tbl[2]  = '{0, 0, 0,  0, 1'b0, -1, 0,  1, 1,  0};
        tbl[3]  = '{2, 3, 6,  4, 1'b1, -1, 0,  2, 1,  1};
        tbl[4]  = '{0, 0, 2, 16, 1'b0, -1, 0,  1, 0,  1};
        tbl[5]  = '{0, 7, 7,  2, 1'b0, -1, 0,  8, 0,  8};
        tbl[6]  = '{7, 0, 1,  3, 1'b0, -1, 0,  8, 0,  8};
        tbl[7]  = '{0, 0, 4,  3, 1'b1, -1, 0,  1, 0,  1};
        tbl[8]  = '{1, 1, 2, 10, 1'b0,  1, 3,  2, 2,  1};
        tbl[9]  = '{1, 1, 1,  5, 1'b0,  0, 5,  1, 2,  0};
        tbl[10] = '{0, 1, 0,  0, 1'b0,  0, 16, 1, 2,  0};
        tbl[11] = '{1, 2, 3, 15, 1'b0, -1, 0,  6, 0,  6};
        tbl[12] = '{3, 3, 5,  5, 1'b0,  2, 0,  3, 2,  2};

        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_op_code = 3'd0;
        cfg_rows    = 3'd0;
        cfg_cols    = 3'd0;
        tp_done     = 1'b0;
        repeat (3) step();

        chk("reset tp_start", tp_start, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset status", status, 0);
        chk("reset tiles_done", tiles_done, 0);
        chk("reset tile ij", {tp_tile_i, tp_tile_j}, 0);
        chk("reset op_code", tp_op_code, 0);
        chk("reset state", dbg_state, 0);
        rst_n = 1'b1;
        step();

        // Directed table.
        for (int t = 0; t < 13; t++) begin
            for (int k = 0; k < 64; k++) lat_arr[k] = tbl[t].lat;
            run_job($sformatf("tbl%0d", t), tbl[t].rows, tbl[t].cols, tbl[t].op,
                    tbl[t].held, tbl[t].ab_tile, tbl[t].ab_m, pulses, st, td);
            chk($sformatf("tbl%0d pulses", t), pulses, tbl[t].e_pulses);
            chk($sformatf("tbl%0d status", t), st, tbl[t].e_status);
            chk($sformatf("tbl%0d tiles", t), td, tbl[t].e_tiles);
            step();
        end

        // Abort while idle changes nothing; last status was abort (tbl12).
        abort = 1'b1;
        repeat (3) step();
        chk("idle abort busy", busy, 0);
        chk("idle abort done", done, 0);
        chk("idle abort status", status, 2);
        abort = 1'b0;
        step();

        // Randomized jobs.
        for (int r = 0; r < 12; r++) begin
            int rows, cols, op, ab_tile, ab_m, eff;
            bit held;
            rows = $urandom_range(0, 7);
            cols = $urandom_range(0, 7);
            op   = $urandom_range(0, 7);
            held = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 64; k++)
                lat_arr[k] = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, TO);
            ab_tile = -1;
            ab_m    = 0;
            if ($urandom_range(0, 3) == 0) begin
                ab_tile = $urandom_range(0, (rows + 1) * (cols + 1) - 1);
                eff = (lat_arr[ab_tile] == 0 || (held && ab_tile > 0)) ? TO : lat_arr[ab_tile];
                if (eff > TO) eff = TO;
                ab_m = $urandom_range(0, eff);
            end
            run_job($sformatf("rnd%0d", r), rows, cols, op, held, ab_tile, ab_m, pulses, st, td);
            step();
        end

        // Reset in the middle of tile (1,0), then a clean job.
        for (int k = 0; k < 64; k++) lat_arr[k] = 10;
        cfg_rows    = 3'd1;
        cfg_cols    = 3'd1;
        cfg_op_code = 3'd6;
        start       = 1'b1;
        found       = 1'b0;
        cd          = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            step();
            start   = 1'b0;
            tp_done = 1'b0;
            if (tp_start) begin
                cd = 10;
                if (tp_tile_i == 3'd1 && tp_tile_j == 3'd0) found = 1'b1;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) tp_done = 1'b1;
            end
        end
        chk("rst seq reached (1,0)", found, 1);
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrst tp_start", tp_start, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst status", status, 0);
        chk("midrst tiles_done", tiles_done, 0);
        chk("midrst tile ij", {tp_tile_i, tp_tile_j}, 0);
        chk("midrst op_code", tp_op_code, 0);
        rst_n     = 1'b1;
        seen_done = 1'b0;
        repeat (5) begin
            step();
            if (done || busy) seen_done = 1'b1;
        end
        chk("no done after reset", seen_done, 0);
        run_job("post_rst", 1, 1, 2, 1'b0, -1, 0, pulses, st, td);
        chk("post_rst pulses", pulses, 4);
        chk("post_rst tiles", td, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
